tap_controller: RTL and testbench
=================================

Name: tap_controller

Overview:
IEEE 1149.1 JTAG TAP controller with a 4-bit instruction register and BYPASS, IDCODE, TCP_CTRL, TCP_STATUS and IJTAG_ACCESS data-register paths. It sits at the chip JTAG pins. It also bridges to an internal IJTAG (IEEE 1687) network through select/capture/shift/update strobes and a serial TDI/TDO pair.

Parameters:
IR_WIDTH, 4, instruction register length
IDCODE_VALUE, 32'h1CAFE0BF, fields {version 4'h1, part 16'hCAFE, manufacturer 11'h05F, 1'b1}
STATUS_VALUE, 32'hDEADBEEF, constant captured by TCP_STATUS

Ports:
TCK  input  1  JTAG test clock; the only clock (up to 10 MHz)
TRST_n  input  1  asynchronous active-low TAP reset
TMS  input  1  test mode select, sampled on TCK rising edge
TDI  input  1  serial data in, sampled on TCK rising edge
TDO  output  1  serial data out, changes on TCK falling edge
ijtag_select  output  1  high while the current instruction is IJTAG_ACCESS
ijtag_capture  output  1  ijtag_select AND state==CAPTURE_DR
ijtag_shift  output  1  ijtag_select AND state==SHIFT_DR
ijtag_update  output  1  ijtag_select AND state==UPDATE_DR
ijtag_tdi  output  1  TDI passed through combinationally
ijtag_tdo  input  1  serial return from the IJTAG network

Behaviour:
- One clock (TCK). Reset is asynchronous and active-low (TRST_n).
- TRST_n low forces the following:
  - state TEST_LOGIC_RESET
  - IR = IDCODE (4'h1)
  - TCP_CTRL = 0
  - all shift registers = 0
  - TDO = 0
- Entering TEST_LOGIC_RESET via TMS also reloads IR = IDCODE synchronously.
- State register is named tap_state. It is a 16-state enum declared inside the module with these names: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR_SCAN, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR.
- State transitions follow the standard 1149.1 TMS graph, advancing on the TCK rising edge. Five TMS=1 clocks reach TEST_LOGIC_RESET from any state.
- Instruction decode:
  - 0x0 BYPASS
  - 0x1 IDCODE
  - 0x8 TCP_CTRL
  - 0x9 TCP_STATUS
  - 0xA IJTAG_ACCESS
  - any other code behaves as BYPASS
- IR operation:
  - CAPTURE_IR loads the IR shift register with 4'b0001.
  - SHIFT_IR shifts LSB first; TDI enters the MSB, and the LSB drives TDO.
  - UPDATE_IR copies the shift register into IR. IR changes only in UPDATE_IR or reset.
- DR operation, rising edge:
  - CAPTURE_DR loads the selected register:
    - BYPASS: 1'b0
    - IDCODE: IDCODE_VALUE
    - TCP_CTRL: current TCP_CTRL
    - TCP_STATUS: STATUS_VALUE
  - SHIFT_DR: 32-bit registers shift right (TDI into bit 31, bit 0 out). BYPASS is 1 bit, TDI to TDO.
  - UPDATE_DR under TCP_CTRL copies the shift register into TCP_CTRL. The other registers ignore update.
- Shift occurs on the SHIFT state's rising edge, including the edge that leaves to EXIT1, so exactly N bits shift for N clocks in SHIFT.
- TDO, falling-edge register:
  - SHIFT_IR: IR shift LSB
  - SHIFT_DR: selected DR LSB, or ijtag_tdo under IJTAG_ACCESS
  - otherwise 0
- Consequence: the bit presented in the first SHIFT cycle is the captured LSB. IDCODE therefore reads 0x1CAFE0BF LSB-first with the first bit = 1.
- Under IJTAG_ACCESS the TAP holds no DR; the IJTAG network owns the data path. The strobes are combinational from tap_state and IR.
- PAUSE/EXIT states hold shift contents unchanged.
- TRST_n asserted mid-shift aborts with no update; TCP_CTRL returns to 0.

Decomposition:
- Package tap_pkg holds: instruction opcode localparams (BYPASS, IDCODE, TCP_CTRL, TCP_STATUS, IJTAG_ACCESS), IDCODE_VALUE, STATUS_VALUE, and the IR capture pattern.
- The state enum stays inside tap_controller so that tap_state and its literals are hierarchically visible to benches.
- No sub-module; FSM, IR and DR mux fit in one module of about 250 lines.

Test Plan:
- TRST_n low then high, 5×TMS=1 -> tap_state==TEST_LOGIC_RESET, TDO=0; TMS=0 -> RUN_TEST_IDLE.
- After reset go to SHIFT_DR with no IR load, shift 32 bits with TDI=0 -> read LSB-first value 0x1CAFE0BF.
- IR=0x0, shift TDI=1 then exit -> first TDO=0 (captured), next TDO=1.
- IR=0x8, write 0xA5A55A5A via update-DR, then a second 32-bit scan -> reads 0xA5A55A5A. Reset, then scan again -> 0x00000000.
- IR=0x9 -> 32-bit read gives 0xDEADBEEF; writes do not change it. IR=0x7 (undefined) -> 1-bit bypass behaviour.
- IR=0xA -> ijtag_capture high in CAPTURE_DR, ijtag_shift high in SHIFT_DR, ijtag_update high in UPDATE_DR, and TDO mirrors ijtag_tdo while shifting. Full DR/IR traversal through the PAUSE/EXIT2 states follows the 1149.1 graph.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared constants for the JTAG TAP: opcodes, captured constants and the DR path selector.
package tap_pkg;

  localparam int IR_WIDTH = 4;
  localparam int DR_WIDTH = 32;

  localparam logic [IR_WIDTH-1:0] BYPASS       = 4'h0;
  localparam logic [IR_WIDTH-1:0] IDCODE       = 4'h1;
  localparam logic [IR_WIDTH-1:0] TCP_CTRL     = 4'h8;
  localparam logic [IR_WIDTH-1:0] TCP_STATUS   = 4'h9;
  localparam logic [IR_WIDTH-1:0] IJTAG_ACCESS = 4'hA;

  // version 4'h1, part 16'hCAFE, manufacturer 11'h05F, mandatory 1
  localparam logic [DR_WIDTH-1:0] IDCODE_VALUE = 32'h1CAFE0BF;
  localparam logic [DR_WIDTH-1:0] STATUS_VALUE = 32'hDEADBEEF;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE   = 4'b0001;

  typedef enum logic [2:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_CTRL,
    DR_STATUS,
    DR_IJTAG
  } dr_sel_t;

  function automatic dr_sel_t decode_ir(input logic [IR_WIDTH-1:0] op);
    dr_sel_t sel;
    case (op)
      IDCODE:       sel = DR_IDCODE;
      TCP_CTRL:     sel = DR_CTRL;
      TCP_STATUS:   sel = DR_STATUS;
      IJTAG_ACCESS: sel = DR_IJTAG;
      default:      sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP with IDCODE/TCP_CTRL/TCP_STATUS/BYPASS DRs and an IJTAG bridge.
// TMS/TDI sampled on TCK rise, TDO registered on TCK fall; no backpressure, TCK paced.
module tap_controller
  import tap_pkg::*;
(
  input  logic TCK,
  input  logic TRST_n,
  input  logic TMS,
  input  logic TDI,
  output logic TDO,
  output logic ijtag_select,
  output logic ijtag_capture,
  output logic ijtag_shift,
  output logic ijtag_update,
  output logic ijtag_tdi,
  input  logic ijtag_tdo
);

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR_SCAN, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_t;

  tap_state_t tap_state, next_state;
  logic [IR_WIDTH-1:0] ir, ir_shift;
  logic [DR_WIDTH-1:0] dr_shift, tcp_ctrl;
  logic bypass_reg, tdo_next;
  dr_sel_t dr_sel;

  assign dr_sel = decode_ir(ir);

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) tap_state <= TEST_LOGIC_RESET;
    else         tap_state <= next_state;
  end

  always_comb begin
    next_state = tap_state;
    unique case (tap_state)
      TEST_LOGIC_RESET: next_state = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    next_state = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   next_state = TMS ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       next_state = TMS ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         next_state = TMS ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         next_state = TMS ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         next_state = TMS ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         next_state = TMS ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        next_state = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   next_state = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       next_state = TMS ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         next_state = TMS ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         next_state = TMS ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         next_state = TMS ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         next_state = TMS ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        next_state = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
    endcase
  end

  // Reaching TEST_LOGIC_RESET through TMS is a soft reset of the instruction.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      ir       <= IDCODE;
      ir_shift <= '0;
    end else begin
      case (tap_state)
        CAPTURE_IR: ir_shift <= IR_CAPTURE;
        SHIFT_IR:   ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        default:    ;
      endcase
      if (next_state == TEST_LOGIC_RESET) ir <= IDCODE;
      else if (tap_state == UPDATE_IR)    ir <= ir_shift;
    end
  end

  // One shared 32-bit shifter serves IDCODE, TCP_CTRL and TCP_STATUS.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      dr_shift   <= '0;
      bypass_reg <= 1'b0;
      tcp_ctrl   <= '0;
    end else begin
      case (tap_state)
        CAPTURE_DR: begin
          case (dr_sel)
            DR_BYPASS: bypass_reg <= 1'b0;
            DR_IDCODE: dr_shift   <= IDCODE_VALUE;
            DR_CTRL:   dr_shift   <= tcp_ctrl;
            DR_STATUS: dr_shift   <= STATUS_VALUE;
            default:   ;
          endcase
        end
        SHIFT_DR: begin
          case (dr_sel)
            DR_BYPASS: bypass_reg <= TDI;
            DR_IJTAG:  ;
            default:   dr_shift   <= {TDI, dr_shift[DR_WIDTH-1:1]};
          endcase
        end
        UPDATE_DR: if (dr_sel == DR_CTRL) tcp_ctrl <= dr_shift;
        default:   ;
      endcase
    end
  end

  always_comb begin
    ijtag_select  = (dr_sel == DR_IJTAG);
    ijtag_capture = ijtag_select && (tap_state == CAPTURE_DR);
    ijtag_shift   = ijtag_select && (tap_state == SHIFT_DR);
    ijtag_update  = ijtag_select && (tap_state == UPDATE_DR);
    ijtag_tdi     = TDI;
    tdo_next      = 1'b0;
    case (tap_state)
      SHIFT_IR: tdo_next = ir_shift[0];
      SHIFT_DR: begin
        case (dr_sel)
          DR_BYPASS: tdo_next = bypass_reg;
          DR_IJTAG:  tdo_next = ijtag_tdo;
          default:   tdo_next = dr_shift[0];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(negedge TCK or negedge TRST_n) begin
    if (!TRST_n) TDO <= 1'b0;
    else         TDO <= tdo_next;
  end

endmodule

// File: tb/tb_tap_controller.sv
// Directed scans plus a random TMS/TDI walk, checked every TCK against a table-driven
// model of the 1149.1 graph and of each data register's contents.
module tb_tap_controller;

  logic TCK = 1'b0, TRST_n = 1'b0, TMS = 1'b1, TDI = 1'b0, ijtag_tdo = 1'b0;
  logic TDO, ijtag_select, ijtag_capture, ijtag_shift, ijtag_update, ijtag_tdi;

  tap_controller dut (
    .TCK(TCK), .TRST_n(TRST_n), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .ijtag_select(ijtag_select), .ijtag_capture(ijtag_capture),
    .ijtag_shift(ijtag_shift), .ijtag_update(ijtag_update),
    .ijtag_tdi(ijtag_tdi), .ijtag_tdo(ijtag_tdo)
  );

  always #50 TCK = ~TCK;

  // State numbering follows the order the states are listed in the TAP definition.
  localparam int S_TLR = 0, S_RTI = 1, S_SELDR = 2, S_CAPDR = 3, S_SHDR = 4, S_EX1DR = 5,
                 S_PDR = 6, S_EX2DR = 7, S_UPDR = 8, S_SELIR = 9, S_CAPIR = 10,
                 S_SHIR = 11, S_EX1IR = 12, S_PIR = 13, S_EX2IR = 14, S_UPIR = 15;
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int checks = 0, errors = 0;
  int m_state;
  logic [3:0]  m_ir, m_irsh;
  logic [31:0] m_dr, m_ctrl;
  logic        m_byp, last_tdo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 bypass, 1 idcode, 2 ctrl, 3 status, 4 ijtag
  function automatic int kind(input logic [3:0] op);
    case (op)
      4'h1: return 1;
      4'h8: return 2;
      4'h9: return 3;
      4'hA: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_tdo();
    int k = kind(m_ir);
    if (m_state == S_SHIR) return m_irsh[0];
    if (m_state != S_SHDR) return 1'b0;
    if (k == 0) return m_byp;
    if (k == 4) return ijtag_tdo;
    return m_dr[0];
  endfunction

  task automatic model_reset();
    m_state = S_TLR; m_ir = 4'h1; m_irsh = '0; m_dr = '0; m_ctrl = '0; m_byp = 1'b0;
  endtask

  task automatic model_edge(input bit tms, input bit tdi);
    int k = kind(m_ir);
    case (m_state)
      S_CAPIR: m_irsh = 4'b0001;
      S_SHIR:  m_irsh = {tdi, m_irsh[3:1]};
      S_UPIR:  m_ir = m_irsh;
      S_CAPDR: begin
        if (k == 0) m_byp = 1'b0;
        else if (k == 1) m_dr = 32'h1CAFE0BF;
        else if (k == 2) m_dr = m_ctrl;
        else if (k == 3) m_dr = 32'hDEADBEEF;
      end
      S_SHDR: begin
        if (k == 0) m_byp = tdi;
        else if (k != 4) m_dr = {tdi, m_dr[31:1]};
      end
      S_UPDR: if (k == 2) m_ctrl = m_dr;
      default: ;
    endcase
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
    if (m_state == S_TLR) m_ir = 4'h1;
  endtask

  task automatic check_outputs();
    logic sel = (kind(m_ir) == 4);
    chk("tap_state", 32'(dut.tap_state), 32'(m_state));
    chk("tdo", 32'(TDO), 32'(exp_tdo()));
    chk("ijtag_select", 32'(ijtag_select), 32'(sel));
    chk("ijtag_capture", 32'(ijtag_capture), 32'(sel && m_state == S_CAPDR));
    chk("ijtag_shift", 32'(ijtag_shift), 32'(sel && m_state == S_SHDR));
    chk("ijtag_update", 32'(ijtag_update), 32'(sel && m_state == S_UPDR));
  endtask

  // Entered and left just after a falling edge.
  task automatic tick(input bit tms, input bit tdi);
    TMS = tms; TDI = tdi; ijtag_tdo = 1'($urandom_range(0, 1));
    #1 chk("ijtag_tdi", 32'(ijtag_tdi), 32'(tdi));
    @(posedge TCK);
    model_edge(tms, tdi);
    @(negedge TCK);
    #1 check_outputs();
    last_tdo = TDO;
  endtask

  task automatic trst();
    TRST_n = 1'b0;
    #10 model_reset();
    check_outputs();
    TRST_n = 1'b1;
    #10;
  endtask

  task automatic scan_ir(input logic [3:0] code);
    logic [3:0] cap;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = last_tdo;
      tick(i == 3, code[i]);
    end
    tick(1, 0); tick(0, 0);
    chk("ir_capture", 32'(cap), 32'h1);
  endtask

  // From RUN_TEST_IDLE; optional detour through PAUSE_DR/EXIT2_DR mid-scan.
  task automatic scan_dr(input int n, input logic [31:0] din, input bit pause,
                         output logic [31:0] dout);
    dout = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = last_tdo;
      if (pause && i == n / 2 - 1) begin
        tick(1, din[i]); tick(0, 0); tick(0, 0); tick(1, 0); tick(0, 0);
      end else begin
        tick(i == n - 1, din[i]);
      end
    end
    tick(1, 0); tick(0, 0);
  endtask

  initial begin
    logic [31:0] d, r;
    model_reset();
    @(negedge TCK);
    #1 trst();
    for (int i = 0; i < 5; i++) tick(1, 1'($urandom_range(0, 1)));
    chk("reset_tdo", 32'(TDO), 32'h0);
    tick(0, 0);

    scan_dr(32, 32'h0, 0, d);
    chk("idcode_read", d, 32'h1CAFE0BF);

    scan_ir(4'h0);
    scan_dr(2, 32'h3, 0, d);
    chk("bypass_read", d, 32'h2);

    scan_ir(4'h8);
    scan_dr(32, 32'hA5A55A5A, 1, d);
    chk("ctrl_initial", d, 32'h0);
    scan_dr(32, 32'h0, 0, d);
    chk("ctrl_readback", d, 32'hA5A55A5A);
    scan_dr(32, 32'hA5A55A5A, 0, d);
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 10; i++) tick(0, 1'($urandom_range(0, 1)));
    trst();
    tick(0, 0);
    scan_ir(4'h8);
    scan_dr(32, $urandom, 0, d);
    chk("ctrl_after_trst", d, 32'h0);

    scan_ir(4'h9);
    scan_dr(32, $urandom, 0, d);
    chk("status_read", d, 32'hDEADBEEF);
    scan_dr(32, $urandom, 1, d);
    chk("status_unwritable", d, 32'hDEADBEEF);

    scan_ir(4'h7);
    r = 32'($urandom_range(0, 255));
    scan_dr(8, r, 1, d);
    chk("undefined_bypass", d, {24'h0, r[6:0], 1'b0});

    scan_ir(4'hA);
    chk("ijtag_select_held", 32'(ijtag_select), 32'h1);
    scan_dr(16, $urandom, 1, d);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) trst();
      tick($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
